// File: rtl/maxpool1d.sv
// Streaming 1-D max pooling over non-overlapping windows of POOL_SIZE signed samples,
// with valid/ready handshakes on both sides and a registered result stage.
module maxpool1d #(
  parameter int DATA_WIDTH = 12,
  parameter int POOL_SIZE  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  maxpool_ready_in,
  input  logic                  maxpool_valid_in,
  input  logic [DATA_WIDTH-1:0] maxpool_data_in,
  input  logic                  maxpool_ready_out,
  output logic                  maxpool_valid_out,
  output logic [DATA_WIDTH-1:0] maxpool_data_out
);

  localparam int CNT_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(POOL_SIZE - 1);

  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] run_max;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] result;
  logic                  in_xfer;
  logic                  out_xfer;

  // The only stall source is a held result that downstream has not taken.
  assign maxpool_ready_in = ~maxpool_valid_out | maxpool_ready_out;
  assign in_xfer          = maxpool_valid_in & maxpool_ready_in;
  assign out_xfer         = maxpool_valid_out & maxpool_ready_out;

  assign merged = ($signed(maxpool_data_in) > $signed(run_max)) ? maxpool_data_in : run_max;
  assign result = (POOL_SIZE == 1) ? maxpool_data_in : merged;

  // A window completion in the same cycle as an output transfer keeps valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count             <= '0;
      run_max           <= '0;
      maxpool_valid_out <= 1'b0;
      maxpool_data_out  <= '0;
    end else begin
      if (out_xfer) begin
        maxpool_valid_out <= 1'b0;
      end
      if (in_xfer) begin
        if (count == LAST) begin
          maxpool_data_out  <= result;
          maxpool_valid_out <= 1'b1;
          count             <= '0;
        end else begin
          run_max <= (count == '0) ? maxpool_data_in : merged;
          count   <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool1d.sv
// Bench for maxpool1d: four instances (POOL_SIZE 1..4) share one input stream and are
// each compared every cycle against a window-list model, plus directed literal checks.
module tb_maxpool1d;

  localparam int NP = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                valid_in;
  logic signed [11:0]  data_in;
  logic                ready_out;
  logic                rdy  [NP];
  logic                vo   [NP];
  logic signed [11:0]  dout [NP];

  int total = 0;
  int bad   = 0;
  logic checking = 1'b0;

  always #5 clk = ~clk;

  maxpool1d #(.DATA_WIDTH(12), .POOL_SIZE(1)) dut_p1 (
    .clk(clk), .rst(rst), .maxpool_ready_in(rdy[0]), .maxpool_valid_in(valid_in),
    .maxpool_data_in(data_in), .maxpool_ready_out(ready_out),
    .maxpool_valid_out(vo[0]), .maxpool_data_out(dout[0]));
  maxpool1d #(.DATA_WIDTH(12), .POOL_SIZE(2)) dut_p2 (
    .clk(clk), .rst(rst), .maxpool_ready_in(rdy[1]), .maxpool_valid_in(valid_in),
    .maxpool_data_in(data_in), .maxpool_ready_out(ready_out),
    .maxpool_valid_out(vo[1]), .maxpool_data_out(dout[1]));
  maxpool1d #(.DATA_WIDTH(12), .POOL_SIZE(3)) dut_p3 (
    .clk(clk), .rst(rst), .maxpool_ready_in(rdy[2]), .maxpool_valid_in(valid_in),
    .maxpool_data_in(data_in), .maxpool_ready_out(ready_out),
    .maxpool_valid_out(vo[2]), .maxpool_data_out(dout[2]));
  maxpool1d #(.DATA_WIDTH(12), .POOL_SIZE(4)) dut_p4 (
    .clk(clk), .rst(rst), .maxpool_ready_in(rdy[3]), .maxpool_valid_in(valid_in),
    .maxpool_data_in(data_in), .maxpool_ready_out(ready_out),
    .maxpool_valid_out(vo[3]), .maxpool_data_out(dout[3]));

  // Reference: collect accepted samples per window, emit the max when the window fills.
  logic signed [11:0] win [NP][4];
  int                 wn  [NP];
  logic               ev  [NP];
  logic signed [11:0] ed  [NP];

  initial begin
    logic               acc;
    logic               done;
    logic signed [11:0] mx;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int k = 0; k < NP; k++) begin
          wn[k] = 0;
          ev[k] = 1'b0;
          ed[k] = '0;
        end
      end else begin
        for (int k = 0; k < NP; k++) begin
          acc  = valid_in && (!ev[k] || ready_out);
          done = 1'b0;
          mx   = ed[k];
          if (acc) begin
            win[k][wn[k]] = data_in;
            wn[k] = wn[k] + 1;
            if (wn[k] == k + 1) begin
              mx = win[k][0];
              for (int i = 1; i < wn[k]; i++) begin
                if (win[k][i] > mx) mx = win[k][i];
              end
              wn[k] = 0;
              done  = 1'b1;
            end
          end
          if (done) begin
            ev[k] = 1'b1;
            ed[k] = mx;
          end else if (ev[k] && ready_out) begin
            ev[k] = 1'b0;
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int k = 0; k < NP; k++) begin
          check_output($sformatf("valid_out p%0d", k + 1), int'(vo[k]), int'(ev[k]));
          check_output($sformatf("data_out p%0d", k + 1), int'(dout[k]), int'(ed[k]));
          check_output($sformatf("ready_in p%0d", k + 1), int'(rdy[k]),
                       int'(!ev[k] || ready_out));
        end
      end
    end
  end

  // Inputs change 1 ns after the falling edge and hold across the next rising edge.
  task automatic apply_stimulus(input logic v, input int d, input logic r);
    valid_in  = v;
    data_in   = 12'(d);
    ready_out = r;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_in  = 1'b0;
    ready_out = 1'b1;
    rst       = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int n1;
    int n2;
    logic v;
    logic r;
    rst       = 1'b1;
    valid_in  = 1'b0;
    data_in   = '0;
    ready_out = 1'b1;
    #1 rst = 1'b0;
    #1 checking = 1'b1;
    for (int k = 0; k < NP; k++) begin
      check_output($sformatf("reset valid p%0d", k + 1), int'(vo[k]), 0);
      check_output($sformatf("reset data p%0d", k + 1), int'(dout[k]), 0);
      check_output($sformatf("reset ready p%0d", k + 1), int'(rdy[k]), 1);
    end
    @(negedge clk);
    #1 rst = 1'b1;

    // Pool of 2 over 3,7,-2,-5
    do_reset();
    apply_stimulus(1, 3, 1);
    apply_stimulus(1, 7, 1);
    check_output("p2 first result valid", int'(vo[1]), 1);
    check_output("p2 first result", int'(dout[1]), 7);
    apply_stimulus(1, -2, 1);
    check_output("p2 valid drops", int'(vo[1]), 0);
    apply_stimulus(1, -5, 1);
    check_output("p2 second result valid", int'(vo[1]), 1);
    check_output("p2 second result", int'(dout[1]), -2);
    apply_stimulus(0, 0, 1);

    // Pool of 3 with downstream stall after the first result
    do_reset();
    apply_stimulus(1, 1, 1);
    apply_stimulus(1, 9, 1);
    apply_stimulus(1, 4, 1);
    check_output("p3 result valid", int'(vo[2]), 1);
    check_output("p3 result", int'(dout[2]), 9);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 5, 0);
      check_output("p3 stalled ready_in", int'(rdy[2]), 0);
      check_output("p3 stalled data", int'(dout[2]), 9);
      check_output("p3 stalled valid", int'(vo[2]), 1);
    end
    apply_stimulus(1, 5, 1);
    check_output("p3 valid cleared", int'(vo[2]), 0);
    apply_stimulus(1, 2, 1);
    apply_stimulus(1, 3, 1);
    check_output("p3 post-stall result", int'(dout[2]), 5);
    check_output("p3 post-stall valid", int'(vo[2]), 1);

    // Continuous stream: no result lost when accept and complete coincide
    do_reset();
    n1 = 0;
    n2 = 0;
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1, int'($urandom_range(0, 4095)), 1);
      n1 += int'(vo[0]);
      n2 += int'(vo[1]);
    end
    apply_stimulus(0, 0, 1);
    n1 += int'(vo[0]);
    n2 += int'(vo[1]);
    check_output("p1 result count", n1, 40);
    check_output("p2 result count", n2, 20);

    // Pool of 4 with input gaps carrying junk data
    do_reset();
    for (int g = 0; g < 4; g++) begin
      repeat (g) apply_stimulus(0, 2047, 1);
      case (g)
        0: apply_stimulus(1, -8, 1);
        1: apply_stimulus(1, -3, 1);
        2: apply_stimulus(1, -8, 1);
        default: apply_stimulus(1, -100, 1);
      endcase
    end
    check_output("p4 result valid", int'(vo[3]), 1);
    check_output("p4 result", int'(dout[3]), -3);

    // Asynchronous reset mid-window discards the partial window
    do_reset();
    apply_stimulus(1, 50, 1);
    apply_stimulus(1, 60, 1);
    check_output("p2 pre-reset valid", int'(vo[1]), 1);
    valid_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_output("p2 async reset valid", int'(vo[1]), 0);
    check_output("p2 async reset data", int'(dout[1]), 0);
    check_output("p3 async reset ready", int'(rdy[2]), 1);
    @(negedge clk);
    #3 rst = 1'b1;
    apply_stimulus(1, 1, 1);
    apply_stimulus(1, 2, 1);
    apply_stimulus(1, 3, 1);
    check_output("p3 after reset valid", int'(vo[2]), 1);
    check_output("p3 after reset result", int'(dout[2]), 3);

    // Pool of 1 at the signed extremes
    do_reset();
    apply_stimulus(1, 2047, 1);
    check_output("p1 max valid", int'(vo[0]), 1);
    check_output("p1 max value", int'(dout[0]), 2047);
    apply_stimulus(1, -2048, 1);
    check_output("p1 min valid", int'(vo[0]), 1);
    check_output("p1 min value", int'(dout[0]), -2048);

    // Random traffic with random backpressure and occasional resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 500 == 499) do_reset();
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 7))
        0: apply_stimulus(v, 2047, r);
        1: apply_stimulus(v, -2048, r);
        default: apply_stimulus(v, int'($urandom_range(0, 4095)), r);
      endcase
    end
    repeat (3) apply_stimulus(0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxpool1d.md
MAXPOOL1D -- requirements
Module: maxpool1d

Interface
REQ-001 Parameter DATA_WIDTH, default 12, width of each signed two's-complement sample in and out.
REQ-002 Parameter POOL_SIZE, default 2, samples per pooling window; legal range 1..256; stride equals POOL_SIZE (non-overlapping windows).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 maxpool_ready_in  output  1  block can accept a sample this cycle.
REQ-006 maxpool_valid_in  input  1  upstream sample valid (driven by conv1d_valid_out).
REQ-007 maxpool_data_in  input  DATA_WIDTH  upstream sample (driven by conv1d_data_out).
REQ-008 maxpool_ready_out  input  1  downstream can accept result.
REQ-009 maxpool_valid_out  output  1  result valid, registered.
REQ-010 maxpool_data_out  output  DATA_WIDTH  pooled maximum, registered.

Function
REQ-011 Input transfer occurs in a cycle when maxpool_valid_in and maxpool_ready_in are both 1; output transfer occurs when maxpool_valid_out and maxpool_ready_out are both 1.
REQ-012 maxpool_ready_in shall equal (~maxpool_valid_out | maxpool_ready_out), combinationally; no other stall source.
REQ-013 Internal window counter, width max(1,clog2(POOL_SIZE)), counts accepted samples 0..POOL_SIZE-1 and advances only on input transfer.
REQ-014 Internal running-max register, DATA_WIDTH, updated only on input transfer.
REQ-015 Input transfer with counter 0: running max loads maxpool_data_in unconditionally (no comparison against stale value).
REQ-016 Input transfer with counter 1..POOL_SIZE-2: running max loads the signed maximum of itself and maxpool_data_in; counter increments.
REQ-017 Input transfer with counter POOL_SIZE-1: maxpool_data_out loads signed max(running max, maxpool_data_in) (just maxpool_data_in when POOL_SIZE=1); maxpool_valid_out set to 1; counter wraps to 0.
REQ-018 Comparison is signed; equal values give the same result either way; no width growth, no saturation.
REQ-019 Latency: result visible on maxpool_data_out the cycle after the final window sample is accepted.
REQ-020 Throughput: one sample per cycle sustained while maxpool_ready_out=1; one result per POOL_SIZE samples.
REQ-021 Output transfer without a simultaneous window completion clears maxpool_valid_out next cycle.
REQ-022 Output transfer simultaneous with window completion: maxpool_valid_out stays 1 and maxpool_data_out takes the new result (set wins over clear).
REQ-023 maxpool_valid_out=1 and maxpool_ready_out=0: maxpool_data_out and maxpool_valid_out held stable; maxpool_ready_in=0, so counter and running max hold.
REQ-024 maxpool_valid_in=0 mid-window: counter and running max hold indefinitely; window resumes on next transfer.
REQ-025 maxpool_data_in ignored whenever no input transfer occurs.

Reset
REQ-026 While rst=0, asynchronously: maxpool_valid_out=0, maxpool_data_out=0, counter=0, running max=0.
REQ-027 Reset asserted mid-window discards the partial window; first accepted sample after release starts a new window at counter 0.
REQ-028 maxpool_ready_in is 1 during and immediately after reset (follows REQ-012 with valid_out=0).

Verification
REQ-029 POOL_SIZE=2, ready_out=1, stream 3,7,-2,-5 back-to-back -> valid_out pulses with data_out=7 then -2, each one cycle after 2nd/4th sample.
REQ-030 POOL_SIZE=3, ready_out held 0 after first result 9 (inputs 1,9,4), then send 5 -> ready_in=0, data_out stays 9, counter stays 0 until ready_out=1.
REQ-031 POOL_SIZE=2, ready_out=1, continuous valid_in -> valid_out stays 1 every other cycle with simultaneous accept/complete never dropping a result; count of results equals samples/2.
REQ-032 POOL_SIZE=4, inputs -8,-3,-8,-100 with valid_in gaps of 0..3 cycles -> single result -3.
REQ-033 POOL_SIZE=3, send 50,60 then rst=0 for 1 cycle (async, mid-cycle), then send 1,2,3 -> valid_out=0 immediately on reset; next result 3, not 60.
REQ-034 POOL_SIZE=1, DATA_WIDTH=12, inputs 2047,-2048 -> results 2047,-2048, one cycle after each.
